// File: rtl/rv_decode_pkg.sv
// Shared RV32 decode definitions: base opcodes, format codes and decoded-bundle sizing.
package rv_decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  localparam int unsigned INSTR_W = 32;

  // Bundle layout: {pc, instr, fmt, illegal, imm}
  function automatic int unsigned dec_w(input int unsigned xlen);
    return 2 * xlen + INSTR_W + 3 + 1;
  endfunction

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Combinational RV32 format classifier and sign-extended immediate generator.
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output fmt_e            o_fmt,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;
  logic        w_s;

  assign w_s = i_instr[31];

  always_comb begin
    o_fmt     = FMT_ILLEGAL;
    o_illegal = 1'b1;
    w_imm32   = '0;
    if (i_instr[1:0] == 2'b11) begin
      case (i_instr[6:0])
        OP_LUI, OP_AUIPC: begin
          o_fmt     = FMT_U;
          o_illegal = 1'b0;
          w_imm32   = {i_instr[31:12], 12'b0};
        end
        OP_JAL: begin
          o_fmt     = FMT_J;
          o_illegal = 1'b0;
          w_imm32   = {{12{w_s}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        end
        OP_JALR, OP_LOAD, OP_IMM: begin
          o_fmt     = FMT_I;
          o_illegal = 1'b0;
          w_imm32   = {{20{w_s}}, i_instr[31:20]};
        end
        OP_STORE: begin
          o_fmt     = FMT_S;
          o_illegal = 1'b0;
          w_imm32   = {{20{w_s}}, i_instr[31:25], i_instr[11:7]};
        end
        OP_BRANCH: begin
          o_fmt     = FMT_B;
          o_illegal = 1'b0;
          w_imm32   = {{19{w_s}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        end
        OP_OP: begin
          o_fmt     = FMT_R;
          o_illegal = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Widen the 32-bit immediate to XLEN, preserving sign
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32 decode stage: 2-entry skid buffer (main + skid slot), flush and
// a saturating count of output handshakes.
module instr_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_count
);

  localparam int unsigned DW = dec_w(XLEN);

  fmt_e            w_fmt;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;
  logic [DW-1:0]   w_dec;
  logic [31:0]     w_main_instr;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_main_free;

  logic [DW-1:0]    r_main;
  logic [DW-1:0]    r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_count;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr   (in_instr),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal),
    .o_imm     (w_imm)
  );

  assign w_dec       = {in_pc, in_instr, w_fmt, w_illegal, w_imm};
  assign in_ready    = !reset && !r_skid_valid;
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_main_valid && out_ready;
  assign w_main_free = !r_main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_out_fire && (r_count != '1))
        r_count <= r_count + CNT_W'(1);
      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_main_free) begin
        // in_ready is low whenever skid holds data, so no new word competes here
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_main_valid <= w_in_fire;
          if (w_in_fire)
            r_main <= w_dec;
        end
      end else if (w_in_fire) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid     = r_main_valid;
  assign out_imm       = r_main[XLEN-1:0];
  assign out_illegal   = r_main[XLEN];
  assign out_fmt       = r_main[XLEN+3:XLEN+1];
  assign w_main_instr  = r_main[XLEN+35:XLEN+4];
  assign out_pc        = r_main[DW-1:XLEN+36];
  assign out_opcode    = w_main_instr[6:0];
  assign out_rd        = w_main_instr[11:7];
  assign out_funct3    = w_main_instr[14:12];
  assign out_rs1       = w_main_instr[19:15];
  assign out_rs2       = w_main_instr[24:20];
  assign out_funct7    = w_main_instr[31:25];
  assign decoded_count = r_count;

endmodule
